// File: rtl/pcpu_pkg.sv
// Shared constants and helpers for the PCPU pipeline.
package pcpu_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ILEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam int PC_STEP = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/pcpu_fifo.sv
// Synchronous FIFO with flush; head entry is visible combinationally so the
// consumer sees the oldest entry in the same cycle it becomes valid.
module pcpu_fifo
  import pcpu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head_data,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so push-while-full is fine then.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/pcpu_fetch_unit.sv
// IF stage: owns the PC, issues credit-limited fetches to a variable-latency
// memory, queues returns and discards responses made stale by a redirect.
module pcpu_fetch_unit
  import pcpu_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int ILEN   = ILEN_DEFAULT,
  parameter int QDEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_stall,
  output logic            if_valid,
  output logic [ILEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4
);

  localparam int CW = clog2(QDEPTH) + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0]      pc_reg, pc_next;
  logic [XLEN-1:0]      resp_pc_reg, resp_pc_next;
  logic [CW-1:0]        inflight_reg, inflight_next;
  logic [CW-1:0]        drop_reg, drop_next;
  logic [CW-1:0]        q_count;
  logic [CW:0]          credit_used;
  logic                 req_fire, q_push, q_pop, q_full, q_empty;
  logic [ILEN+XLEN-1:0] q_head;
  logic [ILEN-1:0]      head_inst;
  logic [XLEN-1:0]      head_pc;

  // Every outstanding request owns a queue slot, so returns can never overflow.
  assign credit_used    = {1'b0, inflight_reg} + {1'b0, q_count};
  assign imem_req_valid = !rst && (credit_used < (CW+1)'(QDEPTH));
  assign imem_req_addr  = pc_reg & ALIGN_MASK;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign q_push         = imem_resp_valid && (drop_reg == '0) && !redirect;
  assign q_pop          = if_valid && !id_stall && !redirect;

  always_comb begin
    inflight_next = inflight_reg + CW'(req_fire) - CW'(imem_resp_valid);
    pc_next       = req_fire ? pc_reg + XLEN'(PC_STEP) : pc_reg;
    resp_pc_next  = q_push ? resp_pc_reg + XLEN'(PC_STEP) : resp_pc_reg;
    drop_next     = drop_reg;
    if (imem_resp_valid && (drop_reg != '0)) begin
      drop_next = drop_reg - CW'(1);
    end
    // Everything still outstanding after this edge belongs to the old path.
    if (redirect) begin
      pc_next      = redirect_pc & ALIGN_MASK;
      resp_pc_next = redirect_pc & ALIGN_MASK;
      drop_next    = inflight_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      resp_pc_reg  <= RESET_PC;
      inflight_reg <= '0;
      drop_reg     <= '0;
    end else begin
      pc_reg       <= pc_next;
      resp_pc_reg  <= resp_pc_next;
      inflight_reg <= inflight_next;
      drop_reg     <= drop_next;
    end
  end

  pcpu_fifo #(
    .WIDTH (ILEN + XLEN),
    .DEPTH (QDEPTH)
  ) u_prefetch_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (q_push),
    .push_data ({imem_resp_data, resp_pc_reg}),
    .pop       (q_pop),
    .head_data (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign head_inst   = q_head[ILEN+XLEN-1:XLEN];
  assign head_pc     = q_head[XLEN-1:0];
  assign if_valid    = !q_empty;
  assign if_inst     = if_valid ? head_inst : ILEN'(NOP_INST);
  assign if_pc       = if_valid ? head_pc : '0;
  assign if_pc_plus4 = if_valid ? head_pc + XLEN'(PC_STEP) : '0;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(q_push && q_full && !q_pop));

endmodule

// File: tb/tb_pcpu_fetch_unit.sv
// Directed bench for pcpu_fetch_unit with a variable-latency in-order memory model.
module tb_pcpu_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  always #5 clk = ~clk;

  pcpu_fetch_unit #(
    .XLEN     (32),
    .ILEN     (32),
    .QDEPTH   (4),
    .RESET_PC (RST_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .id_stall        (id_stall),
    .if_valid        (if_valid),
    .if_inst         (if_inst),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          delivered = 0;
  int          mark;
  logic [31:0] exp_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at negedge, advance the memory model after the edge.
  task automatic cycle();
    logic        acc;
    logic [31:0] acc_addr;
    logic        fire;
    logic        rst_s;
    @(negedge clk);
    acc      = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    fire     = imem_resp_valid;
    rst_s    = rst;
    if (if_valid && !id_stall && !redirect && !rst) begin
      $display("deliver pc=%h inst=%h", if_pc, if_inst);
      check("stream_pc", if_pc, exp_pc);
      check("stream_inst", if_inst, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst_s) begin
      pend.delete();
    end else begin
      if (fire) void'(pend.pop_front());
      if (acc) pend.push_back('{acc_addr, cyc + lat});
    end
    if (!rst_s && pend.size() > 0 && pend[0].due <= cyc + 1) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect = 1'b0; redirect_pc = '0; id_stall = 1'b0;
    exp_pc = RST_PC;
    run(3);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_pc_plus4", if_pc_plus4, 32'h0);

    // Zero-wait stream with wrap through 0xFFFFFFFC.
    rst = 1'b0;
    #1;
    check("c1_req_valid", 32'(imem_req_valid), 32'd1);
    check("c1_req_addr", imem_req_addr, 32'hFFFF_FFF8);
    cycle();
    check("c2_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    check("c2_if_valid", 32'(if_valid), 32'd0);
    cycle();
    check("c3_if_valid", 32'(if_valid), 32'd1);
    check("c3_if_pc", if_pc, 32'hFFFF_FFF8);
    check("c3_if_pc_plus4", if_pc_plus4, 32'hFFFF_FFFC);
    cycle();
    check("c4_if_pc", if_pc, 32'hFFFF_FFFC);
    check("c4_if_pc_plus4_wrap", if_pc_plus4, 32'h0000_0000);
    cycle();
    check("c5_if_pc", if_pc, 32'h0000_0000);
    run(6);

    // Stall for 10 cycles: queue fills, issue stops, stream resumes intact.
    id_stall = 1'b1;
    run(10);
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_if_valid", 32'(if_valid), 32'd1);
    check("stall_head_pc", if_pc, exp_pc);
    id_stall = 1'b0;
    mark = delivered;
    run(10);
    check("stall_resume", 32'(delivered - mark > 6), 32'd1);

    // Latency 3 then redirect with requests in flight.
    lat = 3;
    run(12);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    cycle();
    redirect = 1'b0; exp_pc = 32'h0000_0100;
    check("lat3_redir_addr", imem_req_addr, 32'h0000_0100);
    check("lat3_redir_if_valid", 32'(if_valid), 32'd0);
    mark = delivered;
    run(15);
    check("lat3_progress", 32'(delivered - mark > 5), 32'd1);

    // Redirect coinciding with an accept and a response; misaligned target.
    lat = 1;
    run(8);
    check("same_cyc_req_valid", 32'(imem_req_valid), 32'd1);
    check("same_cyc_resp_valid", 32'(imem_resp_valid), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    cycle();
    redirect = 1'b0; exp_pc = 32'h0000_0200;
    check("same_cyc_addr", imem_req_addr, 32'h0000_0200);
    check("same_cyc_req_valid2", 32'(imem_req_valid), 32'd1);
    mark = delivered;
    run(8);
    check("same_cyc_progress", 32'(delivered - mark > 3), 32'd1);

    // Back-to-back redirects under stall: second one wins.
    lat = 2;
    run(4);
    id_stall = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    cycle();
    redirect_pc = 32'h0000_0400;
    cycle();
    redirect = 1'b0; exp_pc = 32'h0000_0400;
    check("b2b_addr", imem_req_addr, 32'h0000_0400);
    check("b2b_if_valid", 32'(if_valid), 32'd0);
    id_stall = 1'b0;
    mark = delivered;
    run(10);
    check("b2b_progress", 32'(delivered - mark > 3), 32'd1);

    // Reset with queued and in-flight work.
    lat = 3; id_stall = 1'b1;
    run(3);
    check("mrst_pre_if_valid", 32'(if_valid), 32'd1);
    rst = 1'b1;
    cycle();
    check("mrst_if_valid", 32'(if_valid), 32'd0);
    check("mrst_if_inst", if_inst, 32'h0);
    check("mrst_req_valid", 32'(imem_req_valid), 32'd0);
    rst = 1'b0; id_stall = 1'b0; exp_pc = RST_PC;
    #1;
    check("mrst_restart_valid", 32'(imem_req_valid), 32'd1);
    check("mrst_restart_addr", imem_req_addr, RST_PC);
    mark = delivered;
    run(12);
    check("mrst_progress", 32'(delivered - mark > 3), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
